// File: rtl/uart_baud_cfg_ctrl_if.sv
// Signal bundle between the UART register block, transmitter, baud divider and the baud
// reconfiguration sequencer. The master side is the CPU/TX/divider environment.
interface uart_baud_cfg_ctrl_if;
    logic        cfg_req;
    logic [15:0] cfg_divisor;
    logic        cfg_ack;
    logic        cfg_err;
    logic        cfg_busy;
    logic        tx_busy;
    logic        tx_hold;
    logic        baud_clk;
    logic        dlab;
    logic [7:0]  dll;
    logic [7:0]  dlh;
    logic        locked;

    modport master (
        output cfg_req, cfg_divisor, tx_busy, baud_clk,
        input  cfg_ack, cfg_err, cfg_busy, tx_hold, dlab, dll, dlh, locked
    );

    modport slave (
        input  cfg_req, cfg_divisor, tx_busy, baud_clk,
        output cfg_ack, cfg_err, cfg_busy, tx_hold, dlab, dll, dlh, locked
    );
endinterface

// File: rtl/uart_baud_cfg_ctrl.sv
// Run-time UART baud divisor reprogramming: drain TX, load DLL/DLH under DLAB, confirm baud_clk toggles.
// Optional BAUD_PERIOD_CHECK_EN: also verify the baud_clk period against the loaded divisor while syncing.
//
//   state | meaning
//   IDLE  | waiting for cfg_req; also issues the one-cycle reject ack for an illegal divisor
//   DRAIN | tx_hold asserted, waiting for the transmitter to finish its frame
//   LOAD  | dlab high with dll/dlh driven for LOAD_CYCLES cycles
//   SYNC  | counting baud_clk rising edges until lock, or timing out
module uart_baud_cfg_ctrl #(
    parameter int unsigned LOAD_CYCLES  = 2,
    parameter int unsigned IDLE_TIMEOUT = 1024,
    parameter int unsigned LOCK_EDGES   = 2,
    parameter int unsigned MIN_DIV      = 2
) (
    input logic                 clk_cpu,
    input logic                 rst,
    uart_baud_cfg_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_LOAD,
        ST_SYNC
    } state_t;

    localparam logic [15:0] TMO_LAST  = 16'(IDLE_TIMEOUT - 1);
    localparam logic [15:0] LOAD_LAST = 16'(LOAD_CYCLES - 1);
    localparam logic [15:0] EDGE_LAST = 16'(LOCK_EDGES - 1);
    localparam logic [15:0] MIN_DIV_W = 16'(MIN_DIV);

    state_t      state;
    logic [15:0] div_q;
    logic [15:0] tmr_cnt;
    logic [15:0] tmr_inc;
    logic [15:0] ld_cnt;
    logic [15:0] edge_cnt;
    logic        baud_q;
    logic        rise;
    logic        reject_pend;
    logic        ack_q;
    logic        err_q;
    logic        busy_q;
    logic        hold_q;
    logic        dlab_q;
    logic [7:0]  dll_q;
    logic [7:0]  dlh_q;
    logic        locked_q;

    assign rise    = bus.baud_clk & ~baud_q;
    assign tmr_inc = (tmr_cnt == 16'hFFFF) ? tmr_cnt : tmr_cnt + 16'd1;

`ifdef BAUD_PERIOD_CHECK_EN
    // Nominal period 2*(floor(D/2)+1); the first edge has no predecessor so it is not measured.
    logic [16:0] meas_period;
    logic [16:0] req_period;
    logic        period_bad;

    assign meas_period = {1'b0, tmr_cnt} + 17'd1;
    assign req_period  = {1'b0, div_q[15:1], 1'b0} + 17'd2;
    assign period_bad  = (edge_cnt != 16'd0) &&
                         ((meas_period > req_period + 17'd1) ||
                          (meas_period + 17'd1 < req_period));
`endif

    always_ff @(posedge clk_cpu or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            div_q       <= 16'd0;
            tmr_cnt     <= 16'd0;
            ld_cnt      <= 16'd0;
            edge_cnt    <= 16'd0;
            baud_q      <= 1'b0;
            reject_pend <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            hold_q      <= 1'b0;
            dlab_q      <= 1'b0;
            dll_q       <= 8'd0;
            dlh_q       <= 8'd0;
            locked_q    <= 1'b0;
        end else begin
            baud_q <= bus.baud_clk;
            ack_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (reject_pend) begin
                        reject_pend <= 1'b0;
                        ack_q       <= 1'b1;
                        err_q       <= 1'b1;
                        busy_q      <= 1'b0;
                    end else if (bus.cfg_req) begin
                        div_q  <= bus.cfg_divisor;
                        busy_q <= 1'b1;
                        err_q  <= 1'b0;
                        if (bus.cfg_divisor < MIN_DIV_W) begin
                            reject_pend <= 1'b1;
                        end else begin
                            state   <= ST_DRAIN;
                            hold_q  <= 1'b1;
                            tmr_cnt <= 16'd0;
                        end
                    end
                end

                ST_DRAIN: begin
                    // Timeout is checked first so it wins over a same-cycle tx_busy fall.
                    if (tmr_cnt == TMO_LAST) begin
                        state  <= ST_IDLE;
                        ack_q  <= 1'b1;
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        hold_q <= 1'b0;
                    end else begin
                        tmr_cnt <= tmr_inc;
                        if (!bus.tx_busy) begin
                            state    <= ST_LOAD;
                            dlab_q   <= 1'b1;
                            dll_q    <= div_q[7:0];
                            dlh_q    <= div_q[15:8];
                            locked_q <= 1'b0;
                            ld_cnt   <= LOAD_LAST;
                        end
                    end
                end

                ST_LOAD: begin
                    if (ld_cnt == 16'd0) begin
                        state    <= ST_SYNC;
                        dlab_q   <= 1'b0;
                        tmr_cnt  <= 16'd0;
                        edge_cnt <= 16'd0;
                    end else begin
                        ld_cnt <= ld_cnt - 16'd1;
                    end
                end

                ST_SYNC: begin
                    if (rise) begin
`ifdef BAUD_PERIOD_CHECK_EN
                        if (period_bad) begin
                            state    <= ST_IDLE;
                            ack_q    <= 1'b1;
                            err_q    <= 1'b1;
                            busy_q   <= 1'b0;
                            hold_q   <= 1'b0;
                            locked_q <= 1'b0;
                        end else
`endif
                        if (edge_cnt == EDGE_LAST) begin
                            state    <= ST_IDLE;
                            ack_q    <= 1'b1;
                            err_q    <= 1'b0;
                            busy_q   <= 1'b0;
                            hold_q   <= 1'b0;
                            locked_q <= 1'b1;
                        end else begin
                            edge_cnt <= edge_cnt + 16'd1;
                            tmr_cnt  <= 16'd0;
                        end
                    end else if (tmr_cnt == TMO_LAST) begin
                        state    <= ST_IDLE;
                        ack_q    <= 1'b1;
                        err_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        hold_q   <= 1'b0;
                        locked_q <= 1'b0;
                    end else begin
                        tmr_cnt <= tmr_inc;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cfg_ack  = ack_q;
    assign bus.cfg_err  = err_q;
    assign bus.cfg_busy = busy_q;
    assign bus.tx_hold  = hold_q;
    assign bus.dlab     = dlab_q;
    assign bus.dll      = dll_q;
    assign bus.dlh      = dlh_q;
    assign bus.locked   = locked_q;

endmodule

// File: tb/tb_uart_baud_cfg_ctrl.sv
// Bench for uart_baud_cfg_ctrl: directed scenarios plus randomized transactions against a
// cycle-index reference model of the reprogramming sequence.
module tb_uart_baud_cfg_ctrl;
    localparam int LOADC  = 2;
    localparam int TMO    = 16;
    localparam int LOCK   = 2;
    localparam int MINDIV = 2;
    localparam int NW     = 128;

    logic clk_cpu = 1'b0;
    logic rst     = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    uart_baud_cfg_ctrl_if bus ();

    uart_baud_cfg_ctrl #(
        .LOAD_CYCLES (LOADC),
        .IDLE_TIMEOUT(TMO),
        .LOCK_EDGES  (LOCK),
        .MIN_DIV     (MINDIV)
    ) dut (
        .clk_cpu(clk_cpu),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_cpu = ~clk_cpu;

    // baud_clk value presented to the DUT at clock edge k of the current transaction
    logic bw [0:NW+1];

    // observations of one transaction (edge 0 = request accepted)
    int        ob_ack_k, ob_dlab_first, ob_dlab_cnt, ob_hold_cnt, ob_busy_cnt;
    logic      ob_err, ob_hold_ack, ob_busy_ack, ob_ack_next, ob_locked;
    logic [7:0] ob_dll_ld, ob_dlh_ld, ob_dll, ob_dlh;

    // reference model state and expectations
    logic [7:0] m_dll, m_dlh;
    logic       m_locked;
    int         ex_ack_k, ex_dlab_first, ex_dlab_cnt;
    logic       ex_err, ex_hold;

    task automatic gen_baud(input int period, input int high, input int phase);
        for (int k = 0; k <= NW + 1; k++) begin
            if (period == 0) bw[k] = 1'b0;
            else             bw[k] = (((k + phase) % period) < high);
        end
        bw[0] = 1'b0;
    endtask

    // Sync phase entered after edge es: lock after LOCK rising edges, error when TMO edges
    // pass without a rising edge, and (optionally) error on a period off by more than one.
    task automatic model_sync(input int es, input int d);
        int last;
        int n;
        last     = es;
        n        = 0;
        ex_ack_k = -1;
        ex_err   = 1'b1;
        for (int k = es + 1; k <= NW; k++) begin
            if (bw[k] && !bw[k-1]) begin
`ifdef BAUD_PERIOD_CHECK_EN
                if (n > 0 && ((k - last) > 2 * (d / 2 + 1) + 1 || (k - last) < 2 * (d / 2 + 1) - 1)) begin
                    ex_ack_k = k;
                    ex_err   = 1'b1;
                    return;
                end
`endif
                n++;
                if (n == LOCK) begin
                    ex_ack_k = k;
                    ex_err   = 1'b0;
                    return;
                end
                last = k;
            end else if (k - last == TMO) begin
                ex_ack_k = k;
                ex_err   = 1'b1;
                return;
            end
        end
        if (d < 0) ex_err = 1'b1;
    endtask

    task automatic model_txn(input logic [15:0] div, input int nb);
        ex_dlab_first = -1;
        ex_dlab_cnt   = 0;
        if (int'(div) < MINDIV) begin
            ex_ack_k = 1;
            ex_err   = 1'b1;
            ex_hold  = 1'b0;
            return;
        end
        ex_hold = 1'b1;
        if (nb + 1 >= TMO) begin
            ex_ack_k = TMO;
            ex_err   = 1'b1;
            return;
        end
        ex_dlab_first = nb + 1;
        ex_dlab_cnt   = LOADC;
        m_dll         = div[7:0];
        m_dlh         = div[15:8];
        model_sync(nb + 1 + LOADC, int'(div));
        m_locked = !ex_err;
    endtask

    // Drive one request; tx_busy is high for edges 1..nb; observe until one cycle after ack.
    task automatic run_txn(input logic [15:0] div, input int nb);
        ob_ack_k = -1; ob_dlab_first = -1; ob_dlab_cnt = 0; ob_hold_cnt = 0; ob_busy_cnt = 0;
        ob_err = 1'b0; ob_hold_ack = 1'b0; ob_busy_ack = 1'b0; ob_ack_next = 1'b0; ob_locked = 1'b0;
        ob_dll_ld = 8'h00; ob_dlh_ld = 8'h00; ob_dll = 8'h00; ob_dlh = 8'h00;
        bus.cfg_req     = 1'b1;
        bus.cfg_divisor = div;
        bus.tx_busy     = 1'($urandom_range(0, 1));
        bus.baud_clk    = bw[0];
        for (int k = 0; k < NW; k++) begin
            @(negedge clk_cpu);
            if (ob_ack_k < 0) begin
                if (bus.dlab) begin
                    if (ob_dlab_first < 0) begin
                        ob_dlab_first = k;
                        ob_dll_ld     = bus.dll;
                        ob_dlh_ld     = bus.dlh;
                    end
                    ob_dlab_cnt++;
                end
                if (bus.cfg_ack) begin
                    ob_ack_k    = k;
                    ob_err      = bus.cfg_err;
                    ob_hold_ack = bus.tx_hold;
                    ob_busy_ack = bus.cfg_busy;
                    bus.cfg_req = 1'b0;
                end else begin
                    if (bus.tx_hold)  ob_hold_cnt++;
                    if (bus.cfg_busy) ob_busy_cnt++;
                end
            end else begin
                ob_ack_next = bus.cfg_ack;
                ob_dll      = bus.dll;
                ob_dlh      = bus.dlh;
                ob_locked   = bus.locked;
                break;
            end
            bus.tx_busy  = (k + 1 <= nb);
            bus.baud_clk = bw[k+1];
        end
        if (ob_ack_k < 0) $display("FAIL ack_timeout got no cfg_ack within %0d cycles", NW);
        bus.cfg_req  = 1'b0;
        bus.tx_busy  = 1'b0;
        bus.baud_clk = 1'b0;
    endtask

    task automatic test_reset();
        logic [21:0] outs;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_cpu);
            bus.cfg_req     = 1'($urandom_range(0, 1));
            bus.cfg_divisor = 16'($urandom);
            bus.tx_busy     = 1'($urandom_range(0, 1));
            bus.baud_clk    = 1'($urandom_range(0, 1));
        end
        outs = {bus.cfg_ack, bus.cfg_err, bus.cfg_busy, bus.tx_hold, bus.dlab, bus.dll, bus.dlh, bus.locked};
        checks++;
        if (outs !== 22'h0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
        bus.cfg_req = 1'b0; bus.tx_busy = 1'b0; bus.baud_clk = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk_cpu);
        outs = {bus.cfg_ack, bus.cfg_err, bus.cfg_busy, bus.tx_hold, bus.dlab, bus.dll, bus.dlh, bus.locked};
        checks++;
        if (outs !== 22'h0) begin errors++; $display("FAIL post_reset_outputs got %h want 0", outs); end
        m_dll = 8'h00; m_dlh = 8'h00; m_locked = 1'b0;
    endtask

    task automatic test_basic_load();
        gen_baud(4, 2, 2);
        model_txn(16'h0004, 0);
        run_txn(16'h0004, 0);
        checks++;
        if (ob_dlab_first != 1 || ob_dlab_cnt != LOADC) begin
            errors++; $display("FAIL basic_dlab got first=%0d cnt=%0d want first=1 cnt=%0d", ob_dlab_first, ob_dlab_cnt, LOADC);
        end
        checks++;
        if (ob_dll_ld !== 8'h04 || ob_dlh_ld !== 8'h00) begin
            errors++; $display("FAIL basic_bytes got dll=%h dlh=%h want 04 00", ob_dll_ld, ob_dlh_ld);
        end
        checks++;
        if (ob_ack_k != ex_ack_k || ob_err !== 1'b0 || ob_locked !== 1'b1 || ob_hold_ack !== 1'b0) begin
            errors++; $display("FAIL basic_ack got k=%0d err=%b locked=%b hold=%b want k=%0d err=0 locked=1 hold=0",
                               ob_ack_k, ob_err, ob_locked, ob_hold_ack, ex_ack_k);
        end
        checks++;
        if (ob_ack_next !== 1'b0) begin errors++; $display("FAIL basic_ack_pulse got ack=%b after ack want 0", ob_ack_next); end
    endtask

    task automatic test_reject();
        logic [15:0] divs [2];
        divs[0] = 16'h0001;
        divs[1] = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            model_txn(divs[i], 0);
            run_txn(divs[i], 0);
            checks++;
            if (ob_ack_k != 1 || ob_err !== 1'b1 || ob_busy_cnt != 1 || ob_busy_ack !== 1'b0) begin
                errors++; $display("FAIL reject_ack got k=%0d err=%b busy_cnt=%0d busy_ack=%b want k=1 err=1 busy_cnt=1 busy_ack=0",
                                   ob_ack_k, ob_err, ob_busy_cnt, ob_busy_ack);
            end
            checks++;
            if (ob_dlab_cnt != 0 || ob_hold_cnt != 0 || ob_dll !== m_dll || ob_dlh !== m_dlh || ob_locked !== m_locked) begin
                errors++; $display("FAIL reject_keep got dlab=%0d hold=%0d dll=%h dlh=%h locked=%b want 0 0 %h %h %b",
                                   ob_dlab_cnt, ob_hold_cnt, ob_dll, ob_dlh, ob_locked, m_dll, m_dlh, m_locked);
            end
        end
    endtask

    task automatic test_drain_wait();
        gen_baud(5, 2, 0);
        model_txn(16'h1234, 10);
        run_txn(16'h1234, 10);
        checks++;
        if (ob_dlab_first != 11 || ob_dlab_cnt != LOADC) begin
            errors++; $display("FAIL drain_dlab got first=%0d cnt=%0d want first=11 cnt=%0d", ob_dlab_first, ob_dlab_cnt, LOADC);
        end
        checks++;
        if (ob_hold_cnt != ob_ack_k || ob_ack_k != ex_ack_k) begin
            errors++; $display("FAIL drain_hold got hold_cnt=%0d ack_k=%0d want %0d %0d", ob_hold_cnt, ob_ack_k, ex_ack_k, ex_ack_k);
        end
        checks++;
        if (ob_dll_ld !== 8'h34 || ob_dlh_ld !== 8'h12 || ob_locked !== m_locked) begin
            errors++; $display("FAIL drain_bytes got dll=%h dlh=%h locked=%b want 34 12 %b", ob_dll_ld, ob_dlh_ld, ob_locked, m_locked);
        end
    endtask

    task automatic test_drain_timeout();
        int nbs [3];
        nbs[0] = 200;
        nbs[1] = TMO - 1;
        nbs[2] = TMO - 2;
        gen_baud(4, 2, 1);
        for (int i = 0; i < 3; i++) begin
            model_txn(16'h0056, nbs[i]);
            run_txn(16'h0056, nbs[i]);
            checks++;
            if (ob_ack_k != ex_ack_k || ob_err !== ex_err || ob_dlab_first != ex_dlab_first) begin
                errors++; $display("FAIL drain_timeout nb=%0d got k=%0d err=%b dlab_first=%0d want %0d %b %0d",
                                   nbs[i], ob_ack_k, ob_err, ob_dlab_first, ex_ack_k, ex_err, ex_dlab_first);
            end
            checks++;
            if (ob_locked !== m_locked || ob_dll !== m_dll || ob_hold_ack !== 1'b0) begin
                errors++; $display("FAIL drain_timeout_keep nb=%0d got locked=%b dll=%h hold=%b want %b %h 0",
                                   nbs[i], ob_locked, ob_dll, ob_hold_ack, m_locked, m_dll);
            end
        end
    endtask

    task automatic test_sync_timeout();
        gen_baud(0, 0, 0);
        model_txn(16'h0020, 3);
        run_txn(16'h0020, 3);
        checks++;
        if (ob_ack_k != 3 + 1 + LOADC + TMO || ob_err !== 1'b1 || ob_locked !== 1'b0) begin
            errors++; $display("FAIL sync_timeout got k=%0d err=%b locked=%b want k=%0d err=1 locked=0",
                               ob_ack_k, ob_err, ob_locked, 3 + 1 + LOADC + TMO);
        end
    endtask

    task automatic test_period_check();
        int pers [2];
        pers[0] = 9;
        pers[1] = 6;
        for (int i = 0; i < 2; i++) begin
            gen_baud(pers[i], pers[i] / 2, 1);
            model_txn(16'h0004, 0);
            run_txn(16'h0004, 0);
            checks++;
            if (ob_ack_k != ex_ack_k || ob_err !== ex_err || ob_locked !== m_locked) begin
                errors++; $display("FAIL period_%0d got k=%0d err=%b locked=%b want %0d %b %b",
                                   pers[i], ob_ack_k, ob_err, ob_locked, ex_ack_k, ex_err, m_locked);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        bit seen;
        seen = 1'b0;
        bus.cfg_divisor = 16'h00A5; bus.cfg_req = 1'b1; bus.tx_busy = 1'b0; bus.baud_clk = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk_cpu);
            if (bus.dlab) seen = 1'b1;
        end
        bus.cfg_req = 1'b0;
        checks++;
        if (!seen) begin errors++; $display("FAIL mid_load_reach got dlab=0 want dlab=1 within 8 cycles"); end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.dlab !== 1'b0) begin errors++; $display("FAIL mid_load_dlab got %b want 0", bus.dlab); end
        @(negedge clk_cpu);
        rst = 1'b1;
        m_dll = 8'h00; m_dlh = 8'h00; m_locked = 1'b0;
        @(negedge clk_cpu);
        checks++;
        if ({bus.cfg_busy, bus.tx_hold, bus.locked, bus.dll} !== 11'h0) begin
            errors++; $display("FAIL mid_load_idle got busy=%b hold=%b locked=%b dll=%h want 0", bus.cfg_busy, bus.tx_hold, bus.locked, bus.dll);
        end
        run_txn(16'h0001, 0);
        checks++;
        if (ob_ack_k != 1 || ob_err !== 1'b1) begin
            errors++; $display("FAIL mid_load_restart got k=%0d err=%b want 1 1", ob_ack_k, ob_err);
        end
    endtask

    task automatic test_random(input int n);
        logic [15:0] div;
        int nb, per, hi;
        for (int t = 0; t < n; t++) begin
            case ($urandom_range(0, 7))
                0:       div = 16'($urandom_range(0, 1));
                1, 2:    div = 16'($urandom_range(2, 16));
                default: div = 16'($urandom);
            endcase
            nb  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(12, 30)) : int'($urandom_range(0, 8));
            per = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, 24));
            hi  = (per > 1) ? int'($urandom_range(1, per - 1)) : 0;
            gen_baud(per, hi, int'($urandom_range(0, 23)));
            model_txn(div, nb);
            run_txn(div, nb);
            checks++;
            if (ob_ack_k != ex_ack_k || ob_err !== ex_err) begin
                errors++; $display("FAIL rand_ack t=%0d div=%h nb=%0d per=%0d got k=%0d err=%b want k=%0d err=%b",
                                   t, div, nb, per, ob_ack_k, ob_err, ex_ack_k, ex_err);
            end
            checks++;
            if (ob_dlab_first != ex_dlab_first || ob_dlab_cnt != ex_dlab_cnt) begin
                errors++; $display("FAIL rand_dlab t=%0d got first=%0d cnt=%0d want %0d %0d",
                                   t, ob_dlab_first, ob_dlab_cnt, ex_dlab_first, ex_dlab_cnt);
            end
            checks++;
            if (ob_dll !== m_dll || ob_dlh !== m_dlh || ob_locked !== m_locked) begin
                errors++; $display("FAIL rand_regs t=%0d got dll=%h dlh=%h locked=%b want %h %h %b",
                                   t, ob_dll, ob_dlh, ob_locked, m_dll, m_dlh, m_locked);
            end
            checks++;
            if (ob_hold_cnt != (ex_hold ? ex_ack_k : 0) || ob_busy_cnt != ex_ack_k ||
                ob_hold_ack !== 1'b0 || ob_busy_ack !== 1'b0 || ob_ack_next !== 1'b0) begin
                errors++; $display("FAIL rand_flags t=%0d got hold=%0d busy=%0d hold_ack=%b busy_ack=%b ack_next=%b want %0d %0d 0 0 0",
                                   t, ob_hold_cnt, ob_busy_cnt, ob_hold_ack, ob_busy_ack, ob_ack_next,
                                   ex_hold ? ex_ack_k : 0, ex_ack_k);
            end
        end
    endtask

    initial begin
        bus.cfg_req     = 1'b0;
        bus.cfg_divisor = 16'h0000;
        bus.tx_busy     = 1'b0;
        bus.baud_clk    = 1'b0;
        m_dll = 8'h00; m_dlh = 8'h00; m_locked = 1'b0;
        test_reset();
        test_basic_load();
        test_reject();
        test_drain_wait();
        test_drain_timeout();
        test_sync_timeout();
        test_period_check();
        test_reset_mid_load();
        test_random(40);
        test_random(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_baud_cfg_ctrl.md
Name: uart_baud_cfg_ctrl

Overview:
Sequencer that reprograms the UART TX baud divider at run time. It accepts a 16-bit divisor request from the CPU-side register file and holds off new TX frames. It waits for the transmitter to drain, drives the divisor-latch-access (DLAB) bit and the DLL/DLH bytes for a fixed load window, then confirms the baud clock is toggling before acknowledging. It sits between the UART register block and the baud clock divider.

Parameters:
LOAD_CYCLES, 2, number of clk_cpu cycles DLAB is held high with divisor bytes valid (min 1)
IDLE_TIMEOUT, 1024, max clk_cpu cycles spent in DRAIN or SYNC before aborting with error
LOCK_EDGES, 2, baud_clk rising edges required in SYNC before lock is declared (min 1)
MIN_DIV, 2, smallest legal divisor; smaller requests are rejected

Ports:
clk_cpu  in  1  system clock
rst  in  1  asynchronous active-low reset
cfg_req  in  1  request to program cfg_divisor; level, sampled only in IDLE
cfg_divisor  in  16  requested divisor {DLH,DLL}
cfg_ack  out  1  one-cycle completion pulse (success or error)
cfg_err  out  1  valid with cfg_ack; 1 = rejected/aborted
cfg_busy  out  1  high from request acceptance until the cycle of cfg_ack
tx_busy  in  1  transmitter frame in progress
tx_hold  out  1  inhibits TX from starting new frames
baud_clk  in  1  divider output, same clock domain
dlab  out  1  divider load enable (LCR bit 7)
dll  out  8  divisor low byte
dlh  out  8  divisor high byte
locked  out  1  divider programmed and toggling

Behaviour:
- Reset (async, rst=0): state IDLE; dlab=0, dll=0, dlh=0, tx_hold=0, cfg_ack=0, cfg_err=0, cfg_busy=0, locked=0, counters 0. dlab drops immediately, including mid-LOAD.
- States: IDLE, DRAIN, LOAD, SYNC. All outputs are registered.
- IDLE, cfg_req=1: latch cfg_divisor; cfg_busy=1.
  - If divisor < MIN_DIV: next cycle cfg_ack=1, cfg_err=1, cfg_busy=0; dll/dlh/locked unchanged; stay IDLE.
  - Otherwise: go to DRAIN with tx_hold=1 and the timeout counter cleared.
- DRAIN: wait for tx_busy=0.
  - On tx_busy=0, enter LOAD next cycle.
  - If the counter reaches IDLE_TIMEOUT: cfg_ack=1, cfg_err=1, tx_hold=0, back to IDLE. Previous dll/dlh/locked are kept.
- LOAD: dll/dlh = latched divisor bytes; dlab=1 for exactly LOAD_CYCLES cycles; locked=0 on entry. Then dlab=0 and go to SYNC with counters cleared.
- SYNC: baud_clk is registered each cycle; a rising edge is cur=1 & prev=0.
  - Count rising edges. At LOCK_EDGES edges: locked=1, tx_hold=0, cfg_ack=1, cfg_err=0, back to IDLE.
  - No edge within IDLE_TIMEOUT cycles of entry or of the last edge: cfg_ack=1, cfg_err=1, locked=0, tx_hold=0, back to IDLE.
- dll/dlh keep the last loaded value after completion or error.
- cfg_req is ignored outside IDLE. The requester must drop cfg_req in the cycle it sees cfg_ack; req still high in the following IDLE cycle starts a new transaction.
- Timeout counter is 16 bits and saturates (no wrap). IDLE_TIMEOUT must be ≤ 65535.
- tx_busy falling in the same cycle the timeout is reached: the timeout wins.

Optional Feature:
BAUD_PERIOD_CHECK_EN. When defined, SYNC also measures clk_cpu cycles between consecutive baud_clk rising edges. The required period is 2*(floor(D/2)+1); a measurement differing by more than 1 ends SYNC with cfg_ack=1, cfg_err=1, locked=0. When undefined, SYNC counts edges only and no period logic is built.

Test Plan:
- Reset with all inputs toggling -> every output 0; rst low mid-LOAD -> dlab=0 in the same cycle, state IDLE after release.
- cfg_divisor=0x0004, tx_busy=0 -> dlab=1 for 2 cycles with dll=0x04, dlh=0x00; after 2 baud_clk rising edges, cfg_ack=1, cfg_err=0, locked=1, tx_hold=0.
- cfg_divisor=0x0001 -> cfg_ack=1, cfg_err=1 one cycle after the request; dlab never high; dll/dlh unchanged.
- tx_busy=1 for 10 cycles after the request -> tx_hold=1 throughout; dlab rises only in the cycle after tx_busy falls; cfg_divisor=0x1234 gives dll=0x34, dlh=0x12.
- tx_busy stuck at 1 with IDLE_TIMEOUT=16 -> error ack 16 cycles after DRAIN entry; locked keeps its prior value; dlab never asserted.
- baud_clk held 0 after load with IDLE_TIMEOUT=16 -> error ack and locked=0. With BAUD_PERIOD_CHECK_EN and D=4, a baud period of 9 cycles -> error; 6 cycles -> success.
